wavelet_tap_feeder: RTL

//  Producer side of the filter-bank `taps` bus: accepts a stream of BITS_PER_ELEM-bit samples over a

---
 rtl/wavelet_tap_feeder_pkg.sv | 14 +
 rtl/wavelet_tap_feeder_delay_line.sv | 29 ++
 rtl/wavelet_tap_feeder.sv | 103 ++++++++++
 3 files changed

// File: rtl/wavelet_tap_feeder_pkg.sv
// Shared defaults and FSM state encoding for the wavelet tap feeder.
package wavelet_tap_feeder_pkg;

  localparam int DEF_BITS_PER_ELEM = 8;
  localparam int DEF_NUM_ELEM      = 7;
  localparam int DEF_DECIMATE      = 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/wavelet_tap_feeder_delay_line.sv
// Shift-register delay line: element 0 takes the new sample, older elements move up one slot.
module wavelet_delay_line
  import wavelet_tap_feeder_pkg::*;
#(
  parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
  parameter int NUM_ELEM      = DEF_NUM_ELEM
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              en,
  input  logic [BITS_PER_ELEM-1:0]          din,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] taps
);

  logic [NUM_ELEM-1:0][BITS_PER_ELEM-1:0] elem;

  // NOTE: the delay line is a register bank, not a RAM, so it is cleared on reset;
  // the consumer must see all-zero taps after reset or flush.
  always_ff @(posedge clk) begin
    if (clr) begin
      elem <= '0;
    end else if (en) begin
      elem <= {elem[NUM_ELEM-2:0], din};
    end
  end

  assign taps = elem;

endmodule

// File: rtl/wavelet_tap_feeder.sv
// Producer side of the filter-bank taps bus: fills a delay line from a sample stream
// and presents a window every DECIMATE accepted samples once the line is full.
module wavelet_tap_feeder
  import wavelet_tap_feeder_pkg::*;
#(
  parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
  parameter int NUM_ELEM      = DEF_NUM_ELEM,
  parameter int DECIMATE      = DEF_DECIMATE,
  localparam int FW = $clog2(NUM_ELEM + 1),
  localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_flush,
  input  logic [BITS_PER_ELEM-1:0]          i_sample,
  input  logic                              i_sample_valid,
  output logic                              o_sample_ready,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
  output logic                              o_taps_valid,
  input  logic                              i_taps_ready,
  output logic [FW-1:0]                     o_fill_level
);

  state_t        state, state_next;
  logic [FW-1:0] fill_next;
  logic [DW-1:0] decim_cnt, decim_next;
  logic          taps_valid_next;
  logic          accept;
  logic          clear;

  // Ready decodes only the state register, so the consumer's ready never reaches the source.
  assign o_sample_ready = (state != HOLD);
  assign accept         = i_sample_valid & o_sample_ready;
  assign clear          = ~i_rst_n | i_flush;

  wavelet_delay_line #(
    .BITS_PER_ELEM(BITS_PER_ELEM),
    .NUM_ELEM     (NUM_ELEM)
  ) u_delay_line (
    .clk (i_clk),
    .clr (clear),
    .en  (accept),
    .din (i_sample),
    .taps(o_taps)
  );

  // NOTE: every variable is given a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next      = state;
    fill_next       = o_fill_level;
    decim_next      = decim_cnt;
    taps_valid_next = o_taps_valid;
    unique case (state)
      FILL: begin
        if (accept) begin
          fill_next = o_fill_level + FW'(1);
          if (o_fill_level == FW'(NUM_ELEM - 1)) begin
            state_next      = HOLD;
            taps_valid_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (decim_cnt == DW'(DECIMATE - 1)) begin
            decim_next      = '0;
            state_next      = HOLD;
            taps_valid_next = 1'b1;
          end else begin
            decim_next = decim_cnt + DW'(1);
          end
        end
      end
      HOLD: begin
        if (i_taps_ready) begin
          taps_valid_next = 1'b0;
          state_next      = RUN;
        end
      end
      default: begin
        state_next      = FILL;
        taps_valid_next = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (clear) begin
      state        <= FILL;
      o_fill_level <= '0;
      decim_cnt    <= '0;
      o_taps_valid <= 1'b0;
    end else begin
      state        <= state_next;
      o_fill_level <= fill_next;
      decim_cnt    <= decim_next;
      o_taps_valid <= taps_valid_next;
    end
  end

endmodule
